source_char_streamer: RTL
=========================

Name: source_char_streamer

Overview:
- Producer end of the character interface consumed by the assembler's label controller.
- Reads raw assembly source bytes from a text BRAM and emits them one at a time as `new_character` / `new_line` strobes with `incoming_character` and the current line number `pc`.
- Run once per assembler pass (label pass, then encode pass).
- Handles CR dropping, empty-line suppression, missing final newline, consumer stall and line-count overflow.

Parameters:
- NUMBER_LINES, 256, max instruction lines; sets `pc` width `$clog2(NUMBER_LINES)`.
- TEXT_DEPTH, 4096, source BRAM depth in bytes.
- BRAM_LATENCY, 2, read latency of the text BRAM in cycles (≥1).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  one-cycle pulse; begins a pass from address 0.
- pass_in  input  1  0 = label pass, 1 = encode pass; latched on accepted start.
- text_length_in  input  $clog2(TEXT_DEPTH)+1  number of valid source bytes; latched on accepted start.
- text_addr_out  output  $clog2(TEXT_DEPTH)  BRAM read address.
- text_data_in  input  8  BRAM read data, valid BRAM_LATENCY cycles after the address.
- stall_in  input  1  consumer not ready; no strobe may issue while high.
- new_character  output  1  one-cycle strobe; `incoming_character` is valid.
- new_line  output  1  one-cycle strobe; end of the current non-empty line.
- incoming_character  output  8  character being delivered.
- pc  output  $clog2(NUMBER_LINES)  index of the line currently being delivered.
- pass_out  output  1  latched `pass_in`.
- busy_out  output  1  high from accepted start until the `done_flag` cycle inclusive.
- done_flag  output  1  one-cycle pulse at end of pass.
- error_flag  output  1  sticky line-overflow error; cleared on next accepted start.

Behaviour:
Reset values:
- All outputs 0; state IDLE.
- Reset mid-pass aborts immediately, with no `done_flag`.

States:
- IDLE:
  - `start_in` → latch `pass_in` and `text_length_in`, set `idx`=0, `pc`=0, clear `error_flag`, clear `line_has_chars`.
  - If length==0 → DONE, else → FETCH.
  - `start_in` outside IDLE is ignored.
- FETCH:
  - Drive `text_addr_out`=`idx`, count BRAM_LATENCY cycles, capture `text_data_in` into `ch`, `idx`++.
  - Then → CLASSIFY.
- CLASSIFY: one cycle, no strobes.
  - `ch`==0x0D → skip.
  - `ch`==0x0A and `line_has_chars`=1 → LINE_END.
  - `ch`==0x0A and `line_has_chars`=0 → skip (empty line, no strobe, `pc` unchanged).
  - Otherwise → EMIT.
  - "Skip" means: → FETCH if `idx`<length, else → TAIL.
- EMIT:
  - Wait while `stall_in`=1.
  - First cycle with `stall_in`=0: `new_character`=1, `incoming_character`=`ch`, set `line_has_chars`.
  - Then → FETCH, or → TAIL if `idx`==length.
- LINE_END:
  - Wait while `stall_in`=1.
  - Then `new_line`=1 with `pc` still equal to the finished line's index, and clear `line_has_chars`.
  - Overflow case: if `pc`==NUMBER_LINES-1 and more bytes remain (`idx`<length), set `error_flag`, → DONE.
  - Otherwise `pc`++ in the following cycle; → FETCH, or → DONE if `idx`==length.
- TAIL:
  - End of text reached mid-line. If `line_has_chars`=1 → LINE_END (synthesised newline), else → DONE.
- DONE:
  - `done_flag`=1 for one cycle, → IDLE. `pc` holds the final value until the next start.

Strobe and width rules:
- `new_character` and `new_line` are never high in the same cycle.
- Each strobe is exactly one cycle regardless of `stall_in` history.
- Throughput: one byte per BRAM_LATENCY+2 cycles, unstalled.
- `idx` is compared at full width; no address wrap. `text_length_in` > TEXT_DEPTH is clamped to TEXT_DEPTH.

Optional Feature:
- Macro: COMMENT_STRIP_EN.
- Defined:
  - `#` (0x23) enters comment mode. All bytes up to, but not including, 0x0A are skipped with no strobes.
  - 0x0A exits comment mode and follows normal newline rules, so a comment-only line is empty and produces no `new_line`.
  - End of text in comment mode goes to TAIL as normal.
- Undefined: `#` is an ordinary character and is emitted via EMIT.

Test Plan:
1. Text "ab\ncd\n", length 6, `stall_in`=0 → strobes: char 'a' pc0, char 'b' pc0, line pc0, char 'c' pc1, char 'd' pc1, line pc1, then `done_flag`; `error_flag`=0.
2. Text "x\r\n\n\ny" (no final LF) → char 'x' pc0, line pc0, char 'y' pc1, synthesised line pc1, done; exactly 2 `new_line` strobes.
3. Hold `stall_in`=1 for 5 cycles while EMIT has 'q' pending → no strobe during the stall; `new_character` is a single cycle after release; `incoming_character`=0x71.
4. NUMBER_LINES=4, text "a\nb\nc\nd\ne\n" → 4 `new_line` strobes (pc 0..3), `error_flag`=1, `done_flag` pulse, no strobe for 'e'.
5. length=0 with `start_in` → `done_flag` 2 cycles after start, no strobes. A second `start_in` mid-pass is ignored. `rst_in` mid-pass → all outputs 0, no `done_flag`.
6. COMMENT_STRIP_EN defined, text "li #x\n# c\nj\n" → chars 'l','i',' ', line pc0, char 'j' pc1, line pc1. With the macro undefined → '#' is emitted and 3 `new_line` strobes occur.

Source files
------------

// File: rtl/source_char_streamer.sv
// Streams assembly source bytes from a text BRAM as character/line strobes with the current line index.
// Optional macro COMMENT_STRIP_EN drops everything from '#' up to the next line feed.
module source_char_streamer #(
    parameter int NUMBER_LINES = 256,
    parameter int TEXT_DEPTH   = 4096,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    input  logic                            pass_in,
    input  logic [$clog2(TEXT_DEPTH):0]     text_length_in,
    output logic [$clog2(TEXT_DEPTH)-1:0]   text_addr_out,
    input  logic [7:0]                      text_data_in,
    input  logic                            stall_in,
    output logic                            new_character,
    output logic                            new_line,
    output logic [7:0]                      incoming_character,
    output logic [$clog2(NUMBER_LINES)-1:0] pc,
    output logic                            pass_out,
    output logic                            busy_out,
    output logic                            done_flag,
    output logic                            error_flag,
    output logic [2:0]                      state_dbg_o
);
    localparam int AW = $clog2(TEXT_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(NUMBER_LINES);
    localparam int CW = $clog2(BRAM_LATENCY + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(TEXT_DEPTH);
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
`ifdef COMMENT_STRIP_EN
    localparam logic [7:0] HASH = 8'h23;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CLASSIFY, S_EMIT, S_LINE_END, S_TAIL, S_DONE
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [7:0]      ch_q;
    logic [PW-1:0]   pc_q;
    logic [CW-1:0]   lat_q;
    logic            pass_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            has_q;
`ifdef COMMENT_STRIP_EN
    logic            cmt_q;
`endif

    logic [LW-1:0]   len_clamped;
    logic            more_bytes;
    logic            skip_comment;

    assign len_clamped = (text_length_in > DEPTH_L) ? DEPTH_L : text_length_in;
    assign more_bytes  = (idx_q < len_q);

    always_comb begin
        skip_comment = 1'b0;
`ifdef COMMENT_STRIP_EN
        skip_comment = cmt_q ? (ch_q != LF) : (ch_q == HASH);
`endif
    end

    // idx_q doubles as the read address; it sits at the next byte before FETCH
    // begins, so FETCH only has to wait out the BRAM latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            pc_q    <= '0;
            lat_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            has_q   <= 1'b0;
`ifdef COMMENT_STRIP_EN
            cmt_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    idx_q  <= '0;
                    if (start_in) begin
                        busy_q  <= 1'b1;
                        pass_q  <= pass_in;
                        len_q   <= len_clamped;
                        pc_q    <= '0;
                        err_q   <= 1'b0;
                        has_q   <= 1'b0;
                        lat_q   <= '0;
`ifdef COMMENT_STRIP_EN
                        cmt_q   <= 1'b0;
`endif
                        state_q <= (len_clamped == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (lat_q == CW'(BRAM_LATENCY - 1)) begin
                        ch_q    <= text_data_in;
                        idx_q   <= idx_q + LW'(1);
                        lat_q   <= '0;
                        state_q <= S_CLASSIFY;
                    end else begin
                        lat_q <= lat_q + CW'(1);
                    end
                end
                S_CLASSIFY: begin
`ifdef COMMENT_STRIP_EN
                    if (ch_q == LF)        cmt_q <= 1'b0;
                    else if (ch_q == HASH) cmt_q <= 1'b1;
`endif
                    if (skip_comment || ch_q == CR || (ch_q == LF && !has_q))
                        state_q <= more_bytes ? S_FETCH : S_TAIL;
                    else if (ch_q == LF)
                        state_q <= S_LINE_END;
                    else
                        state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (!stall_in) begin
                        has_q   <= 1'b1;
                        state_q <= more_bytes ? S_FETCH : S_TAIL;
                    end
                end
                S_LINE_END: begin
                    if (!stall_in) begin
                        has_q <= 1'b0;
                        if (pc_q == PW'(NUMBER_LINES - 1) && more_bytes) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pc_q    <= pc_q + PW'(1);
                            state_q <= more_bytes ? S_FETCH : S_DONE;
                        end
                    end
                end
                S_TAIL: state_q <= has_q ? S_LINE_END : S_DONE;
                S_DONE: begin
                    done_q  <= 1'b1;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by stall_in in the same cycle so none can appear while the consumer is busy.
    assign new_character      = (state_q == S_EMIT) && !stall_in;
    assign new_line           = (state_q == S_LINE_END) && !stall_in;
    assign incoming_character = ch_q;
    assign text_addr_out      = idx_q[AW-1:0];
    assign pc                 = pc_q;
    assign pass_out           = pass_q;
    assign busy_out           = busy_q;
    assign done_flag          = done_q;
    assign error_flag         = err_q;
    assign state_dbg_o        = state_q;

endmodule
